// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM transmit and receive paths.
package tdm_pkg;

  // Framing state: searching for slot 0, or locked to the frame.
  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_t;

  // Width of a slot index for an n-slot frame. Never narrower than one bit.
  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot index 0..N-1 with clear, load-1 and increment controls.
// The wrap compares against N-1 explicitly, so non-power-of-2 N never
// reaches N.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = slot_w(N)
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          i_inc,
  input  logic          i_clear,
  input  logic          i_load1,
  output logic [SW-1:0] o_slot,
  output logic          o_is_last
);

  localparam logic [SW-1:0] LAST = SW'(N - 1);
  localparam logic [SW-1:0] ONE  = SW'(1);

  logic [SW-1:0] r_slot;

  // Slot register: clear wins over load-1, which wins over increment.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_slot <= '0;
    end else if (i_clear) begin
      r_slot <= '0;
    end else if (i_load1) begin
      r_slot <= ONE;
    end else if (i_inc) begin
      r_slot <= (r_slot == LAST) ? '0 : r_slot + ONE;
    end
  end

  assign o_slot    = r_slot;
  assign o_is_last = (r_slot == LAST);

endmodule

// File: rtl/tdm_demux.sv
// TDM receiver: collects N slot samples into shadow registers and, on the
// last slot, transfers the whole frame to ch_out in a single edge.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 1,
  localparam int SW = slot_w(N)
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic [W-1:0]  din,
  input  logic          din_valid,
  input  logic          frame_sync,
  output logic [W-1:0]  ch_out [N],
  output logic          frame_valid,
  output logic          sync_err,
  output logic [SW-1:0] slot
);

  tdm_state_t    r_state;
  tdm_state_t    w_next_state;
  logic [W-1:0]  r_shadow [N-1];   // slot N-1 goes straight from din to ch_out
  logic [W-1:0]  r_ch_out [N];
  logic          r_frame_valid;
  logic          r_sync_err;

  logic [SW-1:0] w_slot;
  logic          w_is_last;
  logic          w_inc;
  logic          w_clear;
  logic          w_load1;
  logic          w_store;
  logic          w_commit;
  logic          w_err;
  logic [SW-1:0] w_store_idx;

  tdm_slot_counter #(.N(N)) u_slot_counter (
    .clk       (clk),
    .n_reset   (n_reset),
    .i_inc     (w_inc),
    .i_clear   (w_clear),
    .i_load1   (w_load1),
    .o_slot    (w_slot),
    .o_is_last (w_is_last)
  );

  // A sync-marked sample always lands in slot 0, whatever the counter says.
  assign w_store_idx = frame_sync ? '0 : w_slot;

  // Framing decisions for the accepted sample; idle cycles change nothing.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_inc        = 1'b0;
    w_clear      = 1'b0;
    w_load1      = 1'b0;
    w_store      = 1'b0;
    w_commit     = 1'b0;
    w_err        = 1'b0;
    if (din_valid) begin
      unique case (r_state)
        HUNT: begin
          if (frame_sync) begin
            w_store      = 1'b1;
            w_load1      = 1'b1;
            w_next_state = RUN;
          end
        end
        RUN: begin
          if (frame_sync) begin
            // Early sync discards the partial frame and restarts at slot 0.
            w_err   = (w_slot != '0);
            w_store = 1'b1;
            w_load1 = 1'b1;
          end else if (w_slot == '0) begin
            // Expected a frame start but none came: lose lock.
            w_err        = 1'b1;
            w_clear      = 1'b1;
            w_next_state = HUNT;
          end else if (w_is_last) begin
            w_commit = 1'b1;
            w_clear  = 1'b1;
          end else begin
            w_store = 1'b1;
            w_inc   = 1'b1;
          end
        end
        default: w_next_state = HUNT;
      endcase
    end
  end

  // Framing state and single-cycle status pulses.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state       <= HUNT;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_frame_valid <= w_commit;
      r_sync_err    <= w_err;
    end
  end

  // Shadow registers for slots 0..N-2 and the atomic frame transfer.
  // NOTE: these arrays are real registers, not RAM, and must come out of
  // reset as zero, so every element is reset in a loop.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int k = 0; k < N - 1; k++) r_shadow[k] <= '0;
      for (int k = 0; k < N; k++)     r_ch_out[k] <= '0;
    end else begin
      for (int k = 0; k < N - 1; k++) begin
        if (w_store && (w_store_idx == SW'(k))) r_shadow[k] <= din;
      end
      if (w_commit) begin
        for (int k = 0; k < N - 1; k++) r_ch_out[k] <= r_shadow[k];
        r_ch_out[N-1] <= din;
      end
    end
  end

  assign ch_out      = r_ch_out;
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;
  assign slot        = w_slot;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: instance A (N=4, W=1) and instance B
// (N=5, W=8) driven from one linear stimulus sequence.
module tb_tdm_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=4, W=1
  logic       n_reset_a, din_valid_a, frame_sync_a;
  logic [0:0] din_a;
  logic [0:0] ch_a [4];
  logic       fv_a, err_a;
  logic [1:0] slot_a;

  // Instance B: N=5, W=8
  logic       n_reset_b, din_valid_b, frame_sync_b;
  logic [7:0] din_b;
  logic [7:0] ch_b [5];
  logic       fv_b, err_b;
  logic [2:0] slot_b;

  int checks = 0;
  int errors = 0;

  tdm_demux #(.N(4), .W(1)) u_dut_a (
    .clk         (clk),
    .n_reset     (n_reset_a),
    .din         (din_a),
    .din_valid   (din_valid_a),
    .frame_sync  (frame_sync_a),
    .ch_out      (ch_a),
    .frame_valid (fv_a),
    .sync_err    (err_a),
    .slot        (slot_a)
  );

  tdm_demux #(.N(5), .W(8)) u_dut_b (
    .clk         (clk),
    .n_reset     (n_reset_b),
    .din         (din_b),
    .din_valid   (din_valid_b),
    .frame_sync  (frame_sync_b),
    .ch_out      (ch_b),
    .frame_valid (fv_b),
    .sync_err    (err_b),
    .slot        (slot_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected ch_out of A packed as {ch[3],ch[2],ch[1],ch[0]}.
  task automatic chk_a(input string tag, input logic [3:0] ch, input logic fv,
                       input logic err, input logic [1:0] sl);
    check({tag, ".ch"},   64'({ch_a[3], ch_a[2], ch_a[1], ch_a[0]}), 64'(ch));
    check({tag, ".fv"},   64'(fv_a),   64'(fv));
    check({tag, ".err"},  64'(err_a),  64'(err));
    check({tag, ".slot"}, 64'(slot_a), 64'(sl));
  endtask

  // Expected ch_out of B packed as {ch[4],...,ch[0]}.
  task automatic chk_b(input string tag, input logic [39:0] ch, input logic fv,
                       input logic err, input logic [2:0] sl);
    check({tag, ".ch"},   64'({ch_b[4], ch_b[3], ch_b[2], ch_b[1], ch_b[0]}), 64'(ch));
    check({tag, ".fv"},   64'(fv_b),   64'(fv));
    check({tag, ".err"},  64'(err_b),  64'(err));
    check({tag, ".slot"}, 64'(slot_b), 64'(sl));
  endtask

  // Present one cycle of input to A; return 1 time unit after the edge.
  task automatic sa(input logic v, input logic s, input logic d);
    din_valid_a = v; frame_sync_a = s; din_a = d;
    @(posedge clk); #1;
  endtask

  task automatic sb(input logic v, input logic s, input logic [7:0] d);
    din_valid_b = v; frame_sync_b = s; din_b = d;
    @(posedge clk); #1;
  endtask

  initial begin
    n_reset_a = 1'b0; din_valid_a = 1'b0; frame_sync_a = 1'b0; din_a = '0;
    n_reset_b = 1'b0; din_valid_b = 1'b0; frame_sync_b = 1'b0; din_b = '0;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk_a("rst", 4'b0000, 0, 0, 0);
    chk_b("rst_b", 40'h0, 0, 0, 0);
    n_reset_a = 1'b1; n_reset_b = 1'b1;
    repeat (5) sa(0, 0, 0);
    chk_a("idle", 4'b0000, 0, 0, 0);

    // Single contiguous frame 1,0,1,1
    sa(1, 1, 1); chk_a("f1.s0", 4'b0000, 0, 0, 1);
    sa(1, 0, 0); chk_a("f1.s1", 4'b0000, 0, 0, 2);
    sa(1, 0, 1); chk_a("f1.s2", 4'b0000, 0, 0, 3);
    sa(1, 0, 1); chk_a("f1.s3", 4'b1101, 1, 0, 0);
    sa(0, 0, 0); chk_a("f1.after", 4'b1101, 0, 0, 0);

    // Gapped frame 1,0,1,1 then back-to-back frame 0,1,1,0
    sa(1, 1, 1); sa(0, 0, 0);
    sa(1, 0, 0); sa(0, 1, 0);   // sync ignored while din_valid=0
    chk_a("gap.hold", 4'b1101, 0, 0, 2);
    sa(1, 0, 1); sa(0, 0, 0);
    sa(1, 0, 1); chk_a("gap.done", 4'b1101, 1, 0, 0);
    sa(1, 1, 0); chk_a("b2b.s0", 4'b1101, 0, 0, 1);
    sa(1, 0, 1); sa(1, 0, 1);
    sa(1, 0, 0); chk_a("b2b.done", 4'b0110, 1, 0, 0);

    // Early sync: 1,1 then resync with 0,0,1,0
    sa(1, 1, 1); sa(1, 0, 1);
    chk_a("early.pre", 4'b0110, 0, 0, 2);
    sa(1, 1, 0); chk_a("early.err", 4'b0110, 0, 1, 1);
    sa(1, 0, 0); chk_a("early.s1", 4'b0110, 0, 0, 2);
    sa(1, 0, 1);
    sa(1, 0, 0); chk_a("early.done", 4'b0100, 1, 0, 0);

    // Missing sync: slot-0 sample without frame_sync drops to HUNT
    sa(1, 0, 1); chk_a("miss.err", 4'b0100, 0, 1, 0);
    sa(1, 0, 1); sa(1, 0, 1);
    chk_a("miss.hunt", 4'b0100, 0, 0, 0);
    sa(1, 1, 1); sa(1, 0, 1); sa(1, 0, 1);
    sa(1, 0, 1); chk_a("miss.relock", 4'b1111, 1, 0, 0);

    // Asynchronous reset mid-frame, then a fresh frame 0,1,0,1
    sa(1, 1, 0); sa(1, 0, 1);
    din_valid_a = 1'b0;
    #2 n_reset_a = 1'b0;
    #1 chk_a("async_rst", 4'b0000, 0, 0, 0);
    @(posedge clk); #1;
    n_reset_a = 1'b1;
    sa(1, 1, 0); sa(1, 0, 1); sa(1, 0, 0);
    sa(1, 0, 1); chk_a("post_rst", 4'b1010, 1, 0, 0);
    sa(0, 0, 0);

    // N=5, W=8: frames AA,11,22,33,44 then 01,02,03,04,05 back-to-back
    sb(1, 1, 8'hAA); sb(1, 0, 8'h11); sb(1, 0, 8'h22);
    sb(1, 0, 8'h33); chk_b("b.s3", 40'h0, 0, 0, 4);
    sb(1, 0, 8'h44); chk_b("b.f1", 40'h44_33_22_11_AA, 1, 0, 0);
    sb(1, 1, 8'h01); sb(1, 0, 8'h02); sb(1, 0, 8'h03);
    sb(1, 0, 8'h04); chk_b("b.s3b", 40'h44_33_22_11_AA, 0, 0, 4);
    sb(1, 0, 8'h05); chk_b("b.f2", 40'h05_04_03_02_01, 1, 0, 0);
    sb(0, 0, 8'h00); chk_b("b.after", 40'h05_04_03_02_01, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
